// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for a single-port synchronous data SRAM: IDLE -> ISSUE -> RESP per access.
// Define ARB_STATS_EN to add saturating counters st_core, st_dma and st_conflict.
module dmem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_cen,
  output logic              m_wen,
  output logic              m_oen,
  output logic [ADDR_W-1:0] m_a,
  output logic [DATA_W-1:0] m_d,
  input  logic [DATA_W-1:0] m_q
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       st_core,
  output logic [15:0]       st_dma,
  output logic [15:0]       st_conflict
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state, state_nxt;
  logic              grant_dma, grant_dma_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic              cen_nxt, wen_nxt, oen_nxt;
  logic              c_ack_nxt, d_ack_nxt;
  logic [ADDR_W-1:0] a_nxt;
  logic [DATA_W-1:0] d_nxt;
  logic [DATA_W-1:0] c_hold, d_hold;
  logic              pick_dma, sel_we, rd_resp;

  // DMA wins only when it is alone or the core has starved it STARVE_MAX times in a row.
  assign pick_dma = d_req & (~c_req | (starve_cnt == STARVE_LIM));
  assign sel_we   = pick_dma ? d_we : c_we;
  assign rd_resp  = (state == RESP) & ~m_oen;

  always_comb begin
    state_nxt     = state;
    grant_dma_nxt = grant_dma;
    starve_nxt    = starve_cnt;
    cen_nxt       = 1'b1;
    wen_nxt       = 1'b1;
    oen_nxt       = m_oen;
    a_nxt         = m_a;
    d_nxt         = m_d;
    c_ack_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    case (state)
      IDLE: begin
        oen_nxt = 1'b1;
        if (c_req | d_req) begin
          grant_dma_nxt = pick_dma;
          cen_nxt       = 1'b0;
          wen_nxt       = ~sel_we;
          oen_nxt       = sel_we;
          a_nxt         = pick_dma ? d_addr : c_addr;
          d_nxt         = pick_dma ? d_wdata : c_wdata;
          if (pick_dma)
            starve_nxt = '0;
          else if (d_req && (starve_cnt < STARVE_LIM))
            starve_nxt = starve_cnt + 4'd1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        c_ack_nxt = ~grant_dma;
        d_ack_nxt = grant_dma;
        state_nxt = RESP;
      end
      RESP: begin
        oen_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant_dma resets to 1: the last grant is considered to have gone to the DMA port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_dma  <= 1'b1;
      starve_cnt <= '0;
      m_cen      <= 1'b1;
      m_wen      <= 1'b1;
      m_oen      <= 1'b1;
      m_a        <= '0;
      m_d        <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      c_hold     <= '0;
      d_hold     <= '0;
    end else begin
      state      <= state_nxt;
      grant_dma  <= grant_dma_nxt;
      starve_cnt <= starve_nxt;
      m_cen      <= cen_nxt;
      m_wen      <= wen_nxt;
      m_oen      <= oen_nxt;
      m_a        <= a_nxt;
      m_d        <= d_nxt;
      c_ack      <= c_ack_nxt;
      d_ack      <= d_ack_nxt;
      if (rd_resp && !grant_dma) c_hold <= m_q;
      if (rd_resp && grant_dma)  d_hold <= m_q;
    end
  end

  // Read data is forwarded straight from the SRAM during the ack cycle, then held.
  assign c_rdata = (c_ack & ~m_oen) ? m_q : c_hold;
  assign d_rdata = (d_ack & ~m_oen) ? m_q : d_hold;
  assign c_stall = c_req & ~c_ack;

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_core     <= '0;
      st_dma      <= '0;
      st_conflict <= '0;
    end else if (state == IDLE) begin
      if (c_req | d_req) begin
        if (pick_dma) st_dma  <= sat_inc(st_dma);
        else          st_core <= sat_inc(st_core);
      end
      if (c_req & d_req) st_conflict <= sat_inc(st_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: SRAM model, per-port request drivers and a transaction-schedule reference model.
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic [DW-1:0] c_rdata;
  logic          c_ack, c_stall;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_cen, m_wen, m_oen;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [DW-1:0] m_q = '0;
`ifdef ARB_STATS_EN
  logic [15:0]   st_core, st_dma, st_conflict;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_cen(m_cen), .m_wen(m_wen), .m_oen(m_oen), .m_a(m_a), .m_d(m_d), .m_q(m_q)
`ifdef ARB_STATS_EN
    , .st_core(st_core), .st_dma(st_dma), .st_conflict(st_conflict)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port SRAM
  logic [DW-1:0] sram [128];
  always @(posedge clk) begin
    if (!m_cen) begin
      if (!m_wen) sram[m_a] <= m_d;
      else        m_q <= sram[m_a];
    end
  end

  // Reference model: one access at a time, granted on an idle cycle g, command at g+1, ack at g+2.
  logic [DW-1:0] mmem [128];
  bit            act_on, a_dma, a_we;
  logic [AW-1:0] a_addr, l_a;
  logic [DW-1:0] a_wd, a_rd, l_d, ch, dh;
  int            g_cyc, starve, n_c, n_d, n_cf, stall_cnt;
  string         grant_log;

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram[i] = '0;
      mmem[i] = '0;
    end
  end

  always @(negedge clk) begin
    logic e_cen, e_wen, e_oen, e_cack, e_dack;
    logic [DW-1:0] e_crd, e_drd;
    if (rst) begin
      act_on = 0; l_a = '0; l_d = '0; ch = '0; dh = '0;
      starve = 0; n_c = 0; n_d = 0; n_cf = 0;
    end
    e_cen = 1; e_wen = 1; e_oen = 1; e_cack = 0; e_dack = 0; e_crd = ch; e_drd = dh;
    if (act_on && cyc == g_cyc + 1) begin
      e_cen = 0; e_wen = !a_we; e_oen = a_we;
    end else if (act_on && cyc == g_cyc + 2) begin
      e_oen = a_we;
      if (a_dma) begin e_dack = 1; if (!a_we) e_drd = a_rd; end
      else       begin e_cack = 1; if (!a_we) e_crd = a_rd; end
    end
    chk("m_cen", m_cen, e_cen);
    chk("m_wen", m_wen, e_wen);
    chk("m_oen", m_oen, e_oen);
    chk("m_a", m_a, l_a);
    chk("m_d", m_d, l_d);
    chk("c_ack", c_ack, e_cack);
    chk("d_ack", d_ack, e_dack);
    chk("c_rdata", c_rdata, e_crd);
    chk("d_rdata", d_rdata, e_drd);
    chk("c_stall", c_stall, c_req & !e_cack);
`ifdef ARB_STATS_EN
    chk("st_core", st_core, n_c);
    chk("st_dma", st_dma, n_d);
    chk("st_conflict", st_conflict, n_cf);
`endif
    if (!rst) begin
      if (c_stall) stall_cnt++;
      if (act_on && cyc == g_cyc + 1) begin
        if (a_we) mmem[a_addr] = a_wd;
        else      a_rd = mmem[a_addr];
      end else if (act_on && cyc == g_cyc + 2) begin
        if (!a_we) begin
          if (a_dma) dh = a_rd;
          else       ch = a_rd;
        end
        act_on = 0;
      end else if (!act_on) begin
        if (c_req && d_req) n_cf++;
        if (c_req || d_req) begin
          a_dma  = d_req && (!c_req || starve == SMAX);
          a_we   = a_dma ? d_we : c_we;
          a_addr = a_dma ? d_addr : c_addr;
          a_wd   = a_dma ? d_wdata : c_wdata;
          if (a_dma) begin
            starve = 0; n_d++; grant_log = {grant_log, "D"};
          end else begin
            n_c++; grant_log = {grant_log, "C"};
            if (d_req && starve < SMAX) starve++;
          end
          act_on = 1; g_cyc = cyc; l_a = a_addr; l_d = a_wd;
        end
      end
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;
  op_t cq[$];
  op_t dq[$];
  int  c_lat, d_lat;
  int  dack_q[$];

  task automatic run_port(input bit is_dma);
    op_t o;
    int  g, start;
    while ((is_dma ? dq.size() : cq.size()) > 0) begin
      o = is_dma ? dq.pop_front() : cq.pop_front();
      @(posedge clk); #1;
      if (is_dma) begin d_req = 1; d_we = o.we; d_addr = o.a; d_wdata = o.d; end
      else        begin c_req = 1; c_we = o.we; c_addr = o.a; c_wdata = o.d; end
      start = cyc;
      g = 0;
      do begin @(negedge clk); g++; end while (!(is_dma ? d_ack : c_ack) && g < 40);
      chk(is_dma ? "d_ack_wait" : "c_ack_wait", is_dma ? d_ack : c_ack, 1);
      if (is_dma) begin d_lat = cyc - start; dack_q.push_back(cyc); end
      else        c_lat = cyc - start;
    end
    @(posedge clk); #1;
    if (is_dma) d_req = 0;
    else        c_req = 0;
  endtask

  task automatic run_ops();
    fork
      run_port(1'b0);
      run_port(1'b1);
    join
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);

    // Reset in the middle of a core write command aborts it
    #1 c_req = 1; c_we = 1; c_addr = 7'h09; c_wdata = 32'h1111_1111;
    @(posedge clk); #3;
    chk("t1_issue_cen", m_cen, 0);
    rst = 1;
    #1 chk("t1_async_cen", m_cen, 1);
    c_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);

    // Core write then read, uncontended
    s0 = stall_cnt;
    cq.push_back('{1'b1, 7'h05, 32'hDEAD_BEEF});
    cq.push_back('{1'b0, 7'h05, 32'h0});
    run_ops();
    chk("t2_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("t2_latency", c_lat, 2);
    chk("t2_stall_cycles", stall_cnt - s0, 4);
    cq.push_back('{1'b0, 7'h09, 32'h0});
    run_ops();
    chk("t1_aborted_write", c_rdata, 32'h0);

    // DMA-only back-to-back writes
    dack_q.delete();
    dq.push_back('{1'b1, 7'h00, 32'h0000_AAA0});
    dq.push_back('{1'b1, 7'h01, 32'h0000_AAA1});
    dq.push_back('{1'b1, 7'h02, 32'h0000_AAA2});
    run_ops();
    chk("t3_ack_count", dack_q.size(), 3);
    if (dack_q.size() == 3) begin
      chk("t3_gap1", dack_q[1] - dack_q[0], 3);
      chk("t3_gap2", dack_q[2] - dack_q[1], 3);
    end
    chk("t3_latency", d_lat, 2);

    // Continuous contention: starvation limit forces the DMA every fifth grant
    do_reset();
    grant_log = "";
    for (int i = 0; i < 9; i++) cq.push_back('{1'b1, AW'(8'h10 + i), 32'hC000_0000 + i});
    for (int j = 0; j < 2; j++) dq.push_back('{1'b1, AW'(8'h20 + j), 32'hD000_0000 + j});
    run_ops();
    total++;
    if (grant_log != "CCCCDCCCCDC") begin
      bad++;
      $display("FAIL t4_grant_seq actual=%s required=CCCCDCCCCDC", grant_log);
    end
`ifdef ARB_STATS_EN
    chk("t6_st_core", st_core, 9);
    chk("t6_st_dma", st_dma, 2);
    chk("t6_st_conflict", st_conflict, 10);
`endif

    // Core read and DMA write to the same address in the same cycle
    cq.push_back('{1'b0, 7'h10, 32'h0});
    dq.push_back('{1'b1, 7'h10, 32'h0D0D_0D0D});
    run_ops();
    chk("t5_old_data", c_rdata, 32'hC000_0000);
    cq.push_back('{1'b0, 7'h10, 32'h0});
    run_ops();
    chk("t5_new_data", c_rdata, 32'h0D0D_0D0D);
    dq.push_back('{1'b0, 7'h21, 32'h0});
    run_ops();
    chk("t5_dma_read", d_rdata, 32'hD000_0001);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
